enemy_sprite_scheduler: RTL

//  Holds position/type/alive state for up to NUM_ENEMIES on-screen enemies and, per pixel, decides which
//  (if any) covers (hcount_in, vcount_in). Priority-encodes overlaps (lowest index wins) and emits
//  in_sprite/image_addr to drive the shared enemy image ROM + palette renderer. Table updates from game

---
 rtl/enemy_sprite_scheduler.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/enemy_sprite_scheduler.sv
// Per-pixel enemy sprite hit test with a shadow/active table pair committed once per frame.
// Define ENEMY_OVERLAP_DETECT_EN to add overlap_out / overlap_frame_out.
module enemy_sprite_scheduler #(
    parameter int NUM_ENEMIES = 8,
    parameter int SPRITE_W    = 16,
    parameter int SPRITE_H    = 16,
    parameter int NUM_TYPES   = 3,
    parameter int COMMIT_LINE = 720,
    localparam int IDX_W  = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1,
    localparam int ADDR_W = $clog2(SPRITE_W * SPRITE_H * NUM_TYPES),
    localparam int DX_W   = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1,
    localparam int DY_W   = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1
) (
    input  logic              pixel_clk_in,
    input  logic              rst_in,
    input  logic [10:0]       hcount_in,
    input  logic [9:0]        vcount_in,
    input  logic              upd_valid_in,
    output logic              upd_ready_out,
    input  logic [IDX_W-1:0]  upd_idx_in,
    input  logic [10:0]       upd_x_in,
    input  logic [9:0]        upd_y_in,
    input  logic [1:0]        upd_type_in,
    input  logic              upd_alive_in,
    output logic              in_sprite_out,
    output logic [ADDR_W-1:0] image_addr_out,
    output logic [IDX_W-1:0]  enemy_id_out,
    output logic              frame_commit_out
`ifdef ENEMY_OVERLAP_DETECT_EN
    ,
    output logic              overlap_out,
    output logic              overlap_frame_out
`endif
);

    localparam logic [NUM_ENEMIES-1:0] ONE_VEC = NUM_ENEMIES'(1);

    logic run_q;

    logic [10:0] shadowX_q     [NUM_ENEMIES];
    logic [9:0]  shadowY_q     [NUM_ENEMIES];
    logic [1:0]  shadowType_q  [NUM_ENEMIES];
    logic        shadowAlive_q [NUM_ENEMIES];
    logic [10:0] activeX_q     [NUM_ENEMIES];
    logic [9:0]  activeY_q     [NUM_ENEMIES];
    logic [1:0]  activeType_q  [NUM_ENEMIES];
    logic        activeAlive_q [NUM_ENEMIES];

    logic [NUM_ENEMIES-1:0] hit_d, hit_q;
    logic [DX_W-1:0]        dx_d     [NUM_ENEMIES];
    logic [DX_W-1:0]        dx_q     [NUM_ENEMIES];
    logic [DY_W-1:0]        dy_d     [NUM_ENEMIES];
    logic [DY_W-1:0]        dy_q     [NUM_ENEMIES];
    logic [1:0]             typeS1_q [NUM_ENEMIES];

    logic              inSprite_d, inSprite_q;
    logic [IDX_W-1:0]  enemyId_d, enemyId_q;
    logic [ADDR_W-1:0] imageAddr_d, imageAddr_q;

    logic       commitCycle;
    logic       updFire;
    logic [1:0] updTypeClamped;

    // Ready drops in the commit cycle so no write can race the shadow->active copy.
    assign commitCycle      = run_q && (hcount_in == 11'd0) && (vcount_in == 10'(COMMIT_LINE));
    assign upd_ready_out    = run_q && !commitCycle;
    assign updFire          = upd_valid_in && upd_ready_out;
    assign frame_commit_out = commitCycle;

    always_comb begin
        updTypeClamped = upd_type_in;
        if (int'(upd_type_in) >= NUM_TYPES) begin
            updTypeClamped = 2'(NUM_TYPES - 1);
        end
    end

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            run_q <= 1'b0;
            for (int i = 0; i < NUM_ENEMIES; i++) begin
                shadowX_q[i]     <= '0;
                shadowY_q[i]     <= '0;
                shadowType_q[i]  <= '0;
                shadowAlive_q[i] <= 1'b0;
                activeX_q[i]     <= '0;
                activeY_q[i]     <= '0;
                activeType_q[i]  <= '0;
                activeAlive_q[i] <= 1'b0;
            end
        end else begin
            run_q <= 1'b1;
            // Out-of-range indices match no slot, so the handshake completes with no write.
            for (int i = 0; i < NUM_ENEMIES; i++) begin
                if (updFire && (int'(upd_idx_in) == i)) begin
                    shadowX_q[i]     <= upd_x_in;
                    shadowY_q[i]     <= upd_y_in;
                    shadowType_q[i]  <= updTypeClamped;
                    shadowAlive_q[i] <= upd_alive_in;
                end
                if (commitCycle) begin
                    activeX_q[i]     <= shadowX_q[i];
                    activeY_q[i]     <= shadowY_q[i];
                    activeType_q[i]  <= shadowType_q[i];
                    activeAlive_q[i] <= shadowAlive_q[i];
                end
            end
        end
    end

    // Bounds are widened by one bit so sprites near the screen edge cannot wrap into a hit.
    always_comb begin
        hit_d = '0;
        for (int i = 0; i < NUM_ENEMIES; i++) begin
            hit_d[i] = activeAlive_q[i]
                && ({1'b0, hcount_in} >= {1'b0, activeX_q[i]})
                && ({1'b0, hcount_in} < ({1'b0, activeX_q[i]} + 12'(SPRITE_W)))
                && ({1'b0, vcount_in} >= {1'b0, activeY_q[i]})
                && ({1'b0, vcount_in} < ({1'b0, activeY_q[i]} + 11'(SPRITE_H)));
            dx_d[i] = DX_W'(hcount_in - activeX_q[i]);
            dy_d[i] = DY_W'(vcount_in - activeY_q[i]);
        end
    end

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            hit_q <= '0;
            for (int i = 0; i < NUM_ENEMIES; i++) begin
                dx_q[i]     <= '0;
                dy_q[i]     <= '0;
                typeS1_q[i] <= '0;
            end
        end else begin
            hit_q <= hit_d;
            for (int i = 0; i < NUM_ENEMIES; i++) begin
                dx_q[i]     <= dx_d[i];
                dy_q[i]     <= dy_d[i];
                typeS1_q[i] <= activeType_q[i];
            end
        end
    end

    // Walk from the top index down so the lowest-index hit is the one left standing.
    always_comb begin
        inSprite_d  = |hit_q;
        enemyId_d   = '0;
        imageAddr_d = '0;
        for (int i = NUM_ENEMIES - 1; i >= 0; i--) begin
            if (hit_q[i]) begin
                enemyId_d   = IDX_W'(i);
                imageAddr_d = ADDR_W'(((int'(typeS1_q[i]) * SPRITE_H) + int'(dy_q[i])) * SPRITE_W
                                      + int'(dx_q[i]));
            end
        end
    end

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            inSprite_q  <= 1'b0;
            enemyId_q   <= '0;
            imageAddr_q <= '0;
        end else begin
            inSprite_q  <= inSprite_d;
            enemyId_q   <= enemyId_d;
            imageAddr_q <= imageAddr_d;
        end
    end

    assign in_sprite_out  = inSprite_q;
    assign enemy_id_out   = enemyId_q;
    assign image_addr_out = imageAddr_q;

`ifdef ENEMY_OVERLAP_DETECT_EN
    logic overlap_d, overlap_q, overlapFrame_q;

    // Clearing the lowest set bit leaves something only when two or more enemies hit.
    assign overlap_d = (hit_q & (hit_q - ONE_VEC)) != '0;

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            overlap_q      <= 1'b0;
            overlapFrame_q <= 1'b0;
        end else begin
            overlap_q <= overlap_d;
            if (commitCycle) begin
                overlapFrame_q <= 1'b0;
            end else begin
                overlapFrame_q <= overlapFrame_q | overlap_d;
            end
        end
    end

    assign overlap_out       = overlap_q;
    assign overlap_frame_out = overlapFrame_q;
`else
    logic unusedOne;
    assign unusedOne = ^ONE_VEC;
`endif

endmodule
